// File: rtl/serial_pkg.sv
// Shared types and constants for serial_uart_bridge (UART framing and FSM states).
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } serialState_e;

    localparam logic        UART_IDLE_LEVEL = 1'b1;
    localparam int unsigned DATA_BITS       = 8;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead synchronous FIFO; a pop while empty is ignored, a push while full succeeds only alongside a pop.
module byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         dataIn,
    output logic [WIDTH-1:0]         dataOut,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign dataOut = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= dataIn;
    end

endmodule

// File: rtl/serial_uart_bridge.sv
// Processor serial handshake to 8N1 UART bridge with per-direction FIFOs.
// Define SERIAL_LOOPBACK_EN to route the TX bit stream back into the receiver.
module serial_uart_bridge
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data_in,
    input  logic       tx_wren_in,
    output logic       tx_ready_out,
    input  logic       rx_rden_in,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_overflow_out,
    output logic       rx_frame_err_out
);

    localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

    logic [7:0]                  txHead;
    logic                        txFull, txEmpty, txPush, txPop;
    logic [$clog2(FIFO_DEPTH):0] txCount;
    logic                        rxFull, rxEmpty, rxPush, rxPop;
    logic [$clog2(FIFO_DEPTH):0] rxCount;
    logic                        unusedSignals;

    serialState_e txState;
    logic [CW-1:0] txCnt;
    logic [2:0]    txIdx;
    logic [7:0]    txShift;
    logic          txLine;

    serialState_e rxState;
    logic [CW-1:0] rxCnt;
    logic [2:0]    rxIdx;
    logic [7:0]    rxShift;
    logic          rxSrc, rxSync1, rxSync2;

    assign tx_ready_out = !txFull;
    assign txPush       = tx_wren_in && tx_ready_out;
    assign txPop        = !txEmpty &&
                          (txState == IDLE || (txState == STOP && txCnt == BIT_LAST));

    assign rx_valid_out = !rxEmpty;
    assign rxPop        = rx_rden_in && rx_valid_out;
    assign rxPush       = (rxState == STOP) && (rxCnt == BIT_LAST) && rxSync2;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) txFifo (
        .clock(clock), .reset(reset), .push(txPush), .pop(txPop),
        .dataIn(tx_data_in), .dataOut(txHead),
        .full(txFull), .empty(txEmpty), .count(txCount)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) rxFifo (
        .clock(clock), .reset(reset), .push(rxPush), .pop(rxPop),
        .dataIn(rxShift), .dataOut(rx_data_out),
        .full(rxFull), .empty(rxEmpty), .count(rxCount)
    );

`ifdef SERIAL_LOOPBACK_EN
    assign rxSrc         = txLine;
    assign uart_tx_out   = UART_IDLE_LEVEL;
    assign unusedSignals = ^{uart_rx_in, txCount, rxCount};
`else
    assign rxSrc         = uart_rx_in;
    assign uart_tx_out   = txLine;
    assign unusedSignals = ^{txCount, rxCount};
`endif

    // STOP reloads straight into START so queued bytes go out with no idle gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            txState <= IDLE;
            txCnt   <= '0;
            txIdx   <= '0;
            txShift <= '0;
            txLine  <= UART_IDLE_LEVEL;
        end else begin
            case (txState)
                IDLE: begin
                    txLine <= UART_IDLE_LEVEL;
                    if (!txEmpty) begin
                        txShift <= txHead;
                        txCnt   <= '0;
                        txLine  <= 1'b0;
                        txState <= START;
                    end
                end
                START: begin
                    if (txCnt == BIT_LAST) begin
                        txCnt   <= '0;
                        txIdx   <= '0;
                        txLine  <= txShift[0];
                        txState <= DATA;
                    end else begin
                        txCnt <= txCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (txCnt == BIT_LAST) begin
                        txCnt <= '0;
                        if (txIdx == 3'd7) begin
                            txLine  <= UART_IDLE_LEVEL;
                            txState <= STOP;
                        end else begin
                            txIdx  <= txIdx + 3'd1;
                            txLine <= txShift[txIdx + 3'd1];
                        end
                    end else begin
                        txCnt <= txCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (txCnt == BIT_LAST) begin
                        txCnt <= '0;
                        if (!txEmpty) begin
                            txShift <= txHead;
                            txLine  <= 1'b0;
                            txState <= START;
                        end else begin
                            txState <= IDLE;
                        end
                    end else begin
                        txCnt <= txCnt + 1'b1;
                    end
                end
                default: txState <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rxSync1          <= UART_IDLE_LEVEL;
            rxSync2          <= UART_IDLE_LEVEL;
            rxState          <= IDLE;
            rxCnt            <= '0;
            rxIdx            <= '0;
            rxShift          <= '0;
            rx_overflow_out  <= 1'b0;
            rx_frame_err_out <= 1'b0;
        end else begin
            rxSync1 <= rxSrc;
            rxSync2 <= rxSync1;
            case (rxState)
                IDLE: begin
                    if (!rxSync2) begin
                        rxCnt   <= '0;
                        rxState <= START;
                    end
                end
                START: begin
                    if (rxCnt == BIT_HALF) begin
                        rxCnt   <= '0;
                        rxIdx   <= '0;
                        rxState <= rxSync2 ? IDLE : DATA;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rxCnt == BIT_LAST) begin
                        rxCnt          <= '0;
                        rxShift[rxIdx] <= rxSync2;
                        rxIdx          <= rxIdx + 3'd1;
                        if (rxIdx == 3'd7) rxState <= STOP;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rxCnt == BIT_LAST) begin
                        rxCnt   <= '0;
                        rxState <= IDLE;
                        if (!rxSync2)
                            rx_frame_err_out <= 1'b1;
                        else if (rxFull && !rxPop)
                            rx_overflow_out <= 1'b1;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                default: rxState <= IDLE;
            endcase
        end
    end

endmodule
